// File: rtl/shifter_pkg.sv
// Shared types for the datapath 1-bit shifter: operation encoding and code width.
package shifter_pkg;

  localparam int unsigned SHIFT_W = 2;

  typedef enum logic [SHIFT_W-1:0] {
    SH_NONE = 2'b00,
    SH_LSL  = 2'b01,
    SH_LSR  = 2'b10,
    SH_ASR  = 2'b11
  } shift_op_e;

endpackage

// File: rtl/shifter_core.sv
// Combinational 1-bit shifter: pass, LSL, LSR or ASR selected by a fully decoded 2-bit code.
module shifter_core
  import shifter_pkg::*;
#(
  parameter int unsigned data_width = 16
) (
  input  logic [data_width-1:0] in,
  input  logic [SHIFT_W-1:0]    shift,
  output logic [data_width-1:0] r
);

  always_comb begin
    r = in;
    unique case (shift_op_e'(shift))
      SH_NONE: r = in;
      SH_LSL:  r = {in[data_width-2:0], 1'b0};
      SH_LSR:  r = {1'b0, in[data_width-1:1]};
      SH_ASR:  r = {in[data_width-1], in[data_width-1:1]};
    endcase
  end

endmodule

// File: rtl/shifter_unit.sv
// Registered 1-bit shifter between register-file B read and ALU B input.
// Define SHIFTER_STATUS_EN to add registered out_zero / out_neg result flags.
module shifter_unit
  import shifter_pkg::*;
#(
  parameter int unsigned data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [data_width-1:0] in,
  input  logic [SHIFT_W-1:0]    shift,
  output logic [data_width-1:0] sout1,
`ifdef SHIFTER_STATUS_EN
  output logic                  out_zero,
  output logic                  out_neg,
`endif
  output logic                  out_valid
);

  logic [data_width-1:0] r;
  logic [data_width-1:0] sout1_q;
  logic                  valid_q;

  shifter_core #(
    .data_width(data_width)
  ) u_core (
    .in   (in),
    .shift(shift),
    .r    (r)
  );

  // Result only updates on valid input; valid strobe is a plain one-cycle delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sout1_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sout1_q <= r;
      end
    end
  end

  assign sout1     = sout1_q;
  assign out_valid = valid_q;

`ifdef SHIFTER_STATUS_EN
  logic zero_q;
  logic neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (in_valid) begin
      zero_q <= (r == '0);
      neg_q  <= r[data_width-1];
    end
  end

  assign out_zero = zero_q;
  assign out_neg  = neg_q;
`endif

endmodule

// File: tb/tb_shifter_unit.sv
// Self-checking bench for shifter_unit; expected results queued on drive, popped on output.
module tb_shifter_unit;

  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in;
  logic [1:0]    shift;
  logic [DW-1:0] sout1;
  logic          out_valid;
`ifdef SHIFTER_STATUS_EN
  logic          out_zero;
  logic          out_neg;
`endif

  int passed;
  int total;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_v;
  logic [DW-1:0] last_v;

  shifter_unit #(
    .data_width(DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in       (in),
    .shift    (shift),
    .sout1    (sout1),
`ifdef SHIFTER_STATUS_EN
    .out_zero (out_zero),
    .out_neg  (out_neg),
`endif
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [1:0] op);
    logic signed [DW-1:0] s;
    s = d;
    case (op)
      2'd0:    return d;
      2'd1:    return d << 1;
      2'd2:    return d >> 1;
      default: return s >>> 1;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic [1:0] op, input logic v);
    in       = d;
    shift    = op;
    in_valid = v;
    if (v) sb.push_back(model(d, op));
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in       = DW'($urandom);
    shift    = 2'($urandom);
    repeat (3) step();
    total++;
    if (sout1 !== '0 || out_valid !== 1'b0) begin
      $display("FAIL reset_hold: sout1=%h valid=%b want 0000/0", sout1, out_valid);
    end else passed++;
    rst_n = 1'b1;
    drive(16'hA5A5, 2'd0, 1'b1);
    step();
    total++;
    if (out_valid !== 1'b1 || sout1 !== 16'hA5A5) begin
      $display("FAIL reset_release: sout1=%h valid=%b want a5a5/1", sout1, out_valid);
    end else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (sout1 !== '0 || out_valid !== 1'b0) begin
      $display("FAIL reset_async: sout1=%h valid=%b want 0000/0", sout1, out_valid);
    end else passed++;
    sb.delete();
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    last_v = '0;
  endtask

  // Drives one valid vector and checks it one edge later.
  task automatic test_vector(input string name, input logic [DW-1:0] d, input logic [1:0] op);
    drive(d, op, 1'b1);
    step();
    exp_v = sb.pop_front();
    total++;
    if (out_valid !== 1'b1 || sout1 !== exp_v) begin
      $display("FAIL %s: sout1=%h valid=%b want %h/1", name, sout1, out_valid, exp_v);
    end else passed++;
    last_v = exp_v;
  endtask

  task automatic test_pass();
    test_vector("pass", 16'hF0CF, 2'd0);
    total++;
    if (sout1 !== 16'hF0CF) $display("FAIL pass_const: sout1=%h want f0cf", sout1);
    else passed++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_lsl();
    test_vector("lsl", 16'hF0CF, 2'd1);
    total++;
    if (sout1 !== 16'hE19E) $display("FAIL lsl_const: sout1=%h want e19e", sout1);
    else passed++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_shift_right();
    logic [DW-1:0] want[3] = '{16'h7867, 16'hF867, 16'h3C33};
    logic [DW-1:0] din[3]  = '{16'hF0CF, 16'hF0CF, 16'h7867};
    logic [1:0]    ops[3]  = '{2'd2, 2'd3, 2'd3};
    for (int i = 0; i < 3; i++) begin
      test_vector("shr", din[i], ops[i]);
      total++;
      if (sout1 !== want[i]) $display("FAIL shr_const%0d: sout1=%h want %h", i, sout1, want[i]);
      else passed++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] want[4] = '{16'hF0CF, 16'hE19E, 16'h7867, 16'hF867};
    drive(16'hF0CF, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      if (i < 3) drive(16'hF0CF, 2'(i + 1), 1'b1);
      else in_valid = 1'b0;
      exp_v = sb.pop_front();
      total++;
      if (out_valid !== 1'b1 || sout1 !== exp_v || sout1 !== want[i]) begin
        $display("FAIL b2b%0d: sout1=%h valid=%b want %h/1", i, sout1, out_valid, want[i]);
      end else passed++;
    end
    repeat (2) begin
      step();
      total++;
      if (out_valid !== 1'b0 || sout1 !== 16'hF867) begin
        $display("FAIL hold: sout1=%h valid=%b want f867/0", sout1, out_valid);
      end else passed++;
    end
    last_v = 16'hF867;
  endtask

  task automatic test_boundary();
    test_vector("ones_asr", 16'hFFFF, 2'd3);
    test_vector("msb_lsl", 16'h8000, 2'd1);
    test_vector("one_lsr", 16'h0001, 2'd2);
    test_vector("one_asr", 16'h0001, 2'd3);
    for (int op = 0; op < 4; op++) test_vector("zero", 16'h0000, 2'(op));
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic [1:0]    op;
    logic          v;
    for (int i = 0; i < 24; i++) begin
      d  = DW'($urandom);
      op = 2'($urandom_range(0, 3));
      v  = 1'($urandom_range(0, 1));
      drive(d, op, v);
      step();
      total++;
      if (v) begin
        exp_v = sb.pop_front();
        if (out_valid !== 1'b1 || sout1 !== exp_v) begin
          $display("FAIL rand%0d: sout1=%h valid=%b want %h/1", i, sout1, out_valid, exp_v);
        end else passed++;
        last_v = exp_v;
      end else begin
        if (out_valid !== 1'b0 || sout1 !== last_v) begin
          $display("FAIL rand_hold%0d: sout1=%h valid=%b want %h/0", i, sout1, out_valid, last_v);
        end else passed++;
      end
    end
    in_valid = 1'b0;
    step();
  endtask

`ifdef SHIFTER_STATUS_EN
  task automatic test_status();
    test_vector("st_zero", 16'h0001, 2'd2);
    total++;
    if (out_zero !== 1'b1 || out_neg !== 1'b0) begin
      $display("FAIL status_zero: z=%b n=%b want 1/0", out_zero, out_neg);
    end else passed++;
    test_vector("st_neg", 16'h8000, 2'd3);
    total++;
    if (sout1 !== 16'hC000 || out_zero !== 1'b0 || out_neg !== 1'b1) begin
      $display("FAIL status_neg: sout1=%h z=%b n=%b want c000/0/1", sout1, out_zero, out_neg);
    end else passed++;
    drive(16'h0000, 2'd0, 1'b0);
    step();
    total++;
    if (out_zero !== 1'b0 || out_neg !== 1'b1) begin
      $display("FAIL status_hold: z=%b n=%b want 0/1", out_zero, out_neg);
    end else passed++;
  endtask
`endif

  initial begin
    passed   = 0;
    total    = 0;
    last_v   = '0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in       = '0;
    shift    = '0;
    test_reset();
    test_pass();
    test_lsl();
    test_shift_right();
    test_back_to_back();
    test_boundary();
    test_random();
`ifdef SHIFTER_STATUS_EN
    test_status();
`endif
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_drain: left=%0d want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
